// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the 9-bit core.
// Parses a byte stream (16-bit word count, then two bytes per instruction),
// writes each assembled instruction into instruction memory, holds the core
// in reset while loading, then counts core cycles until the core halts.
module imem_loader #(
    parameter int instr_width = 9,
    parameter int addr_width  = 9,
    parameter int byte_width  = 8
) (
    input  logic                   clk,
    input  logic                   start,
    input  logic                   in_valid,
    input  logic [byte_width-1:0]  in_data,
    output logic                   in_ready,
    output logic                   imem_we,
    output logic [addr_width-1:0]  imem_addr,
    output logic [instr_width-1:0] imem_din,
    output logic                   core_start,
    input  logic                   core_halt,
    output logic                   done,
    output logic                   err,
    output logic [15:0]            run_cycles
);

    typedef enum logic [2:0] {
        S_HDR_LO,
        S_HDR_HI,
        S_W_LO,
        S_W_HI,
        S_WRITE,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    // Largest legal word count: one full memory image.
    localparam logic [16:0] DEPTH = 17'(1) << addr_width;

    state_t                 state, state_nxt;
    logic [15:0]            count_q, count_nxt;
    logic [addr_width-1:0]  wr_addr_q, wr_addr_nxt;
    logic [byte_width-1:0]  lo_q, lo_nxt;
    logic [addr_width-1:0]  addr_q, addr_nxt;
    logic [instr_width-1:0] din_q, din_nxt;
    logic [15:0]            run_q, run_nxt;

    logic                   rdy_state;
    logic                   accept;
    logic [15:0]            hdr_count;
    logic                   last_word;
    logic                   hi_bad;

    // Stream-facing states are the only ones that take bytes.
    assign rdy_state = (state == S_HDR_LO) || (state == S_HDR_HI) ||
                       (state == S_W_LO)   || (state == S_W_HI);
    assign accept    = in_valid && rdy_state && !start;

    // Full word count as it stands once the high header byte arrives.
    assign hdr_count = 16'({in_data, count_q[byte_width-1:0]});
    assign last_word = (16'(wr_addr_q) == (count_q - 16'd1));
    assign hi_bad    = |in_data[byte_width-1:1];

    // Next-state and datapath decode for the loader FSM.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_nxt   = state;
        count_nxt   = count_q;
        wr_addr_nxt = wr_addr_q;
        lo_nxt      = lo_q;
        addr_nxt    = addr_q;
        din_nxt     = din_q;
        run_nxt     = run_q;

        unique case (state)
            S_HDR_LO: begin
                if (accept) begin
                    count_nxt = 16'(in_data);
                    state_nxt = S_HDR_HI;
                end
            end
            S_HDR_HI: begin
                if (accept) begin
                    count_nxt = hdr_count;
                    if ((hdr_count == 16'd0) || ({1'b0, hdr_count} > DEPTH)) begin
                        state_nxt = S_ERR;
                    end else begin
                        wr_addr_nxt = '0;
                        state_nxt   = S_W_LO;
                    end
                end
            end
            S_W_LO: begin
                if (accept) begin
                    lo_nxt    = in_data;
                    state_nxt = S_W_HI;
                end
            end
            S_W_HI: begin
                if (accept) begin
                    if (hi_bad) begin
                        state_nxt = S_ERR;
                    end else begin
                        // Present address/data ahead of the write cycle; they hold afterwards.
                        addr_nxt  = wr_addr_q;
                        din_nxt   = instr_width'({in_data[0], lo_q});
                        state_nxt = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (last_word) begin
                    state_nxt = S_RUN;
                end else begin
                    wr_addr_nxt = wr_addr_q + addr_width'(1);
                    state_nxt   = S_W_LO;
                end
            end
            S_RUN: begin
                if (core_halt) begin
                    state_nxt = S_DONE;
                end else if (run_q != 16'hFFFF) begin
                    run_nxt = run_q + 16'd1;
                end
            end
            S_DONE:  state_nxt = S_DONE;
            S_ERR:   state_nxt = S_ERR;
            default: state_nxt = S_ERR;
        endcase
    end

    // State and datapath registers; start restarts the loader from the header.
    always_ff @(posedge clk) begin
        // NOTE: registered state uses non-blocking assignments so all updates land together at the edge.
        if (start) begin
            state     <= S_HDR_LO;
            count_q   <= '0;
            wr_addr_q <= '0;
            lo_q      <= '0;
            addr_q    <= '0;
            din_q     <= '0;
            run_q     <= '0;
        end else begin
            state     <= state_nxt;
            count_q   <= count_nxt;
            wr_addr_q <= wr_addr_nxt;
            lo_q      <= lo_nxt;
            addr_q    <= addr_nxt;
            din_q     <= din_nxt;
            run_q     <= run_nxt;
        end
    end

    // Outputs come from registered state only; start forces the idle values.
    assign in_ready   = rdy_state && !start;
    assign imem_we    = (state == S_WRITE) && !start;
    assign imem_addr  = start ? '0 : addr_q;
    assign imem_din   = start ? '0 : din_q;
    assign core_start = start || !((state == S_RUN) || (state == S_DONE));
    assign done       = (state == S_DONE) && !start;
    assign err        = (state == S_ERR) && !start;
    assign run_cycles = run_q;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the 9-bit core. It accepts a byte stream over a valid/ready handshake and assembles 9-bit instruction words from byte pairs. It writes those words sequentially into instruction memory, the storage the fetch unit reads. It holds the core in `start` while loading, releases it when the load is complete, then counts core cycles until `halt`.

## Interface
- `instr_width`, 9, instruction word width
- `addr_width`, 9, instruction memory address width; depth = 2^addr_width
- `byte_width`, 8, input stream width
- `clk`  in  1  clock; all state changes on rising edge
- `start`  in  1  synchronous active-high reset
- `in_valid`  in  1  stream byte valid
- `in_data`  in  8  stream byte
- `in_ready`  out  1  loader accepts byte this cycle
- `imem_we`  out  1  instruction memory write strobe
- `imem_addr`  out  addr_width  write address
- `imem_din`  out  instr_width  write data
- `core_start`  out  1  drives core `start`; high holds the core in reset
- `core_halt`  in  1  core `halt`
- `done`  out  1  core halted after a successful load
- `err`  out  1  malformed stream detected
- `run_cycles`  out  16  core cycles counted in RUN, saturating

## Operation
- Byte accept: `in_valid & in_ready` at a rising edge. `in_ready` is gated by `~start`.
- Stream format:
  - Byte 0 = `count[7:0]`; byte 1 = `count[15:8]`.
  - Then `count` instruction words, 2 bytes each: low byte = `instr[7:0]`; high byte bit 0 = `instr[8]`.
  - High byte bits [7:1] must be 0.
- FSM states: HDR_LO, HDR_HI, W_LO, W_HI, WRITE, RUN, DONE, ERR.
  - HDR_LO: `in_ready`=1. On accept, latch `count` low byte and go to HDR_HI.
  - HDR_HI: `in_ready`=1. On accept, latch `count` high byte.
    - If `count`==0 or `count` > 2^addr_width, go to ERR.
    - Otherwise clear `wr_addr`=0 and go to W_LO.
  - W_LO: `in_ready`=1. On accept, latch the low byte and go to W_HI.
  - W_HI: `in_ready`=1. On accept:
    - if bits [7:1] ≠ 0, go to ERR;
    - otherwise latch bit 0 and go to WRITE.
  - WRITE: `in_ready`=0, `imem_we`=1 for exactly this one cycle, `imem_addr`=`wr_addr`, `imem_din`={bit8, low byte}.
    - If `wr_addr`==`count`−1, go to RUN.
    - Otherwise `wr_addr`++ and go to W_LO.
  - RUN: `core_start`=0, `in_ready`=0.
    - `run_cycles` increments each cycle, saturating at 16'hFFFF.
    - When `core_halt`=1 is sampled, go to DONE; that cycle is not counted.
  - DONE: `done`=1; `core_start`=0; `run_cycles` frozen. Remains until `start`.
  - ERR: `err`=1, `core_start`=1, `in_ready`=0, `imem_we`=0. Remains until `start`.
- `core_start`=1 in every state except RUN and DONE.
- `core_halt` is ignored outside RUN; the core is held in reset there.
- `imem_addr`/`imem_din` hold their last values when `imem_we`=0.
- Bytes arriving after the final word are not accepted (`in_ready`=0).

## Timing
- Reset: any edge with `start`=1 sets state HDR_LO, `wr_addr`=0, `count`=0, `run_cycles`=0.
  - While `start`=1: `in_ready`=0, `imem_we`=0, `core_start`=1, `done`=0, `err`=0, `imem_addr`=0, `imem_din`=0.
- `start` mid-load or mid-run aborts immediately to HDR_LO. Memory already written is not cleared.
- All outputs are decoded from registered state. There is no combinational path from `in_valid`/`in_data` to any output.
- Per word: minimum 3 cycles (W_LO, W_HI, WRITE) with `in_valid` held high. `in_valid` gaps stall the FSM in W_LO/W_HI with no side effects.
- Write latency: `imem_we` is asserted in the cycle after the high byte is accepted.
- Core release: `core_start` falls in the cycle after the last WRITE. The core's first active cycle is the first RUN cycle, counted as `run_cycles`=1 at the next edge.
- Full-depth load (`count`=2^addr_width): last write at address 2^addr_width−1; `wr_addr` never wraps.

## Test plan
- Basic load:
  - stimulus: stream 03 00, A5 01, 3C 00, FF 01 with no gaps;
  - required response: writes (0,0x1A5), (1,0x03C), (2,0x1FF), each a single-cycle `imem_we`; `core_start` falls the cycle after the third write.
- Backpressure/gaps:
  - stimulus: same stream with `in_valid` low 0–4 random cycles between bytes;
  - required response: identical write sequence; no extra `imem_we` pulses.
- Errors:
  - stimulus (a): header 00 00; required response: `err`=1, no writes, `core_start` stays 1.
  - stimulus (b): word high byte 0x02; required response: `err`=1; prior words already written; no write for the bad word.
  - stimulus (c): count 0x0201 with addr_width=9; required response: `err`=1.
- Run/halt:
  - stimulus: after load, assert `core_halt` on the 10th RUN cycle;
  - required response: `done`=1, `run_cycles`=9, frozen; later `core_halt` toggles have no effect.
- Reset mid-load:
  - stimulus: pulse `start` after the 2nd word, then send a fresh 1-word stream 01 00 77 00;
  - required response: single write (0,0x077), then RUN.
- Saturation:
  - stimulus: hold `core_halt`=0 for 70000 RUN cycles;
  - required response: `run_cycles`=0xFFFF, no wrap.
